// File: rtl/serial_adder.sv
// serial_adder: bit-serial unsigned adder computing a+b+cin one bit per cycle, LSB first.
// Latency: WIDTH+1 edges from accepted start to the one-cycle done pulse; WIDTH+2 cycles per op back to back.
// Backpressure: none; start is only sampled in IDLE and is dropped (not queued) while busy or done.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int CW = $clog2(WIDTH);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // Holds the WIDTH-1 low sum bits; the final bit is merged in on the completing edge.
  logic [WIDTH-2:0] psum;
  logic             c;
  logic [CW-1:0]    cnt;

  logic             s_bit;
  logic             c_next;
  logic             last;
  logic [WIDTH-1:0] psum_ext;

  // One full-adder slice on the current LSBs plus the carry flop.
  always_comb begin
    s_bit    = a_sh[0] ^ b_sh[0] ^ c;
    c_next   = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
    psum_ext = {s_bit, psum};
    last     = (cnt == CW'(WIDTH - 1));
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Sequencer and datapath: load on start, shift one bit per RUN cycle, publish result on the last bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      psum  <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            c     <= cin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          c    <= c_next;
          psum <= psum_ext[WIDTH-1:1];
          cnt  <= cnt + CW'(1);
          if (last) begin
            sum   <= psum_ext;
            cout  <= c_next;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  // Signed overflow: on the MSB slice, carry in (c) differs from carry out (c_next).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (state == RUN && last) begin
      ovf <= c ^ c_next;
    end
  end
`else
  // Overflow tracking not built in this configuration.
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder at WIDTH=8: directed literal cases plus a start-held random run.
// An arithmetic reference tracks operation timing and results and is compared on every cycle.
// Literal expectations in the directed cases pin the reference model itself.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
  logic         done;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sum   (sum),
    .cout  (cout),
    .busy  (busy),
    .done  (done)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: m_t counts cycles since the accepting edge (0 = idle).
  int           m_t = 0;
  logic [W-1:0] m_sum = '0;
  logic         m_cout = 1'b0;
  logic         m_ovf = 1'b0;
  logic [W-1:0] p_sum = '0;
  logic         p_cout = 1'b0;
  logic         p_ovf = 1'b0;

  always @(posedge clk) begin
    int tot;
    int sa;
    int sb;
    int st;
    if (!rst_n) begin
      m_t = 0; m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
    end else if (m_t == 0) begin
      if (start) begin
        tot    = int'(a) + int'(b) + int'(cin);
        p_sum  = tot[W-1:0];
        p_cout = tot[W];
        sa     = a[W-1] ? int'(a) - 256 : int'(a);
        sb     = b[W-1] ? int'(b) - 256 : int'(b);
        st     = sa + sb + int'(cin);
        p_ovf  = (st > 127) || (st < -128);
        m_t    = 1;
      end
    end else if (m_t <= W) begin
      m_t = m_t + 1;
      if (m_t == W + 1) begin
        m_sum = p_sum; m_cout = p_cout; m_ovf = p_ovf;
      end
    end else begin
      m_t = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmp_busy", 32'(busy), 32'((m_t >= 1) && (m_t <= W)));
      chk("cmp_done", 32'(done), 32'(m_t == W + 1));
      chk("cmp_sum",  32'(sum),  32'(m_sum));
      chk("cmp_cout", 32'(cout), 32'(m_cout));
`ifdef SERIAL_ADDER_OVF_EN
      chk("cmp_ovf",  32'(ovf),  32'(m_ovf));
`endif
    end
  end

  // Called just after a negedge with the DUT idle; inj=1 pulses start with new operands at RUN cycle 3.
  task automatic op(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic cc, input int inj,
                    input logic [W-1:0] es, input logic ec, input logic eo, input string nm);
    int busy_n = 0;
    int done_n = 0;
    int done_at = 0;
    logic [W-1:0] s_at = '0;
    logic c_at = 1'b0;
    logic o_at = 1'b0;
    a = aa; b = bb; cin = cc; start = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_n == 1) begin
          done_at = i; s_at = sum; c_at = cout;
`ifdef SERIAL_ADDER_OVF_EN
          o_at = ovf;
`endif
        end
      end
      if (inj == 1 && i == 3) begin
        start = 1'b1; a = ~aa; b = bb + 8'd1; cin = ~cc;
      end
      if (inj == 1 && i == 4) start = 1'b0;
    end
    chk({nm, "_busy_cycles"}, 32'(busy_n), 32'(W));
    chk({nm, "_done_count"}, 32'(done_n), 32'd1);
    chk({nm, "_done_edge"}, 32'(done_at), 32'(W + 1));
    chk({nm, "_sum"}, 32'(s_at), 32'(es));
    chk({nm, "_cout"}, 32'(c_at), 32'(ec));
`ifdef SERIAL_ADDER_OVF_EN
    chk({nm, "_ovf"}, 32'(o_at), 32'(eo));
`else
    if (eo !== o_at && eo !== 1'b0) begin end
`endif
  endtask

  initial begin
    int ndone;
    int cyc;
    int last_done;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum",  32'(sum),  32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    op(8'h5A, 8'h33, 1'b0, 0, 8'h8D, 1'b0, 1'b1, "add_5a_33");
    op(8'hFF, 8'h01, 1'b0, 0, 8'h00, 1'b1, 1'b0, "add_ff_01");
    op(8'hFF, 8'hFF, 1'b1, 0, 8'hFF, 1'b1, 1'b0, "add_ff_ff_c");
    op(8'h12, 8'h34, 1'b1, 1, 8'h47, 1'b0, 1'b0, "ignore_start");

    // Abort mid-RUN with reset: result clears and no done appears.
    begin
      int dn = 0;
      a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
      for (int i = 1; i <= 14; i++) begin
        @(negedge clk);
        if (i == 1) start = 1'b0;
        if (done) dn++;
        if (i == 4) rst_n = 1'b0;
        if (i == 5) begin
          rst_n = 1'b1;
          chk("abort_busy", 32'(busy), 32'd0);
          chk("abort_sum",  32'(sum),  32'd0);
          chk("abort_cout", 32'(cout), 32'd0);
        end
      end
      chk("abort_no_done", 32'(dn), 32'd0);
    end
    op(8'h01, 8'h02, 1'b0, 0, 8'h03, 1'b0, 1'b0, "after_abort");

`ifdef SERIAL_ADDER_OVF_EN
    op(8'h7F, 8'h01, 1'b0, 0, 8'h80, 1'b0, 1'b1, "ovf_7f_01");
    op(8'h80, 8'h80, 1'b0, 0, 8'h00, 1'b1, 1'b1, "ovf_80_80");
    op(8'h10, 8'h20, 1'b0, 0, 8'h30, 1'b0, 1'b0, "ovf_10_20");
`endif

    // Start held high with fresh random operands every cycle.
    ndone = 0; cyc = 0; last_done = 0;
    start = 1'b1;
    while (ndone < 1000 && cyc < 10300) begin
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      @(negedge clk);
      cyc++;
      if (done) begin
        ndone++;
        if (ndone > 1) chk("rand_period", 32'(cyc - last_done), 32'(W + 2));
        last_done = cyc;
      end
    end
    start = 1'b0;
    chk("rand_done_total", 32'(ndone), 32'd1000);
    repeat (12) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
